instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage that produces the instruction word whose opcode field feeds the opcode decoder. It is the supplying end of the decoder's `ins` interface.
- Holds the PC and issues word reads to instruction memory through a req/ready handshake.
- Presents one instruction at a time to decode through a valid/ready handshake.
- Redirects the PC when decode reports a taken beq (Branch && zero).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- halt  input  1  when high, no new fetch request is issued.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  word-aligned read address (= pc).
- imem_ready  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word from memory.
- ins_valid  output  1  ins/opcode/ins_pc hold a valid instruction.
- dec_ready  input  1  decode accepts the held instruction this cycle.
- ins  output  32  held instruction register.
- opcode  output  6  ins[31:26]; drives the decoder's 6-bit opcode input.
- ins_pc  output  32  address the held instruction was fetched from.
- branch  input  1  decoder Branch signal for the held instruction.
- zero  input  1  ALU zero flag for the held instruction.
- fetch_count  output  32  number of instructions accepted by decode.

Behaviour:
- Reset (asynchronous on rst_n low, any state, including mid-handshake):
  - state=S_FETCH, pc=RESET_PC, ins=0, ins_pc=0, fetch_count=0.
  - ins_valid=0, imem_req=~halt.
  - ins=0 decodes as R-type; consumers qualify it with ins_valid.
  - Any in-flight memory response is discarded.
- State machine, two states:
  - S_FETCH:
    - ins_valid=0.
    - imem_req = ~halt (combinational); imem_addr = pc.
    - Capture occurs only when imem_req && imem_ready. On capture: ins<=imem_rdata, ins_pc<=pc, pc<=pc+4, next state S_HOLD.
    - imem_ready while imem_req=0 is ignored.
  - S_HOLD:
    - ins_valid=1, imem_req=0.
    - ins, ins_pc and pc are stable while dec_ready=0, for any number of cycles.
    - On dec_ready: fetch_count<=fetch_count+1 (wraps mod 2^32), next state S_FETCH.
    - If branch && zero are also high in that cycle: pc <= ins_pc + 4 + (sign_extend(ins[15:0]) << 2).
    - Otherwise pc keeps the ins_pc+4 value already loaded at capture.
- branch and zero are sampled only in S_HOLD on the dec_ready cycle; ignored elsewhere.
- halt affects only S_FETCH request issue. halt asserted in S_HOLD has no effect until the state returns to S_FETCH.
- Latency and throughput:
  - Minimum one instruction per 2 cycles: 1 fetch cycle with immediate ready, plus 1 hold cycle with immediate dec_ready.
  - Each memory wait cycle adds one cycle.
- Arithmetic:
  - All PC arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC fetches, then pc wraps to 0.
  - The branch target wraps the same way.
  - pc[1:0] is always 00; the shifted offset keeps alignment.
- Simultaneous events:
  - halt and imem_ready high together in S_FETCH: no capture, because imem_req=0.
  - Reset overrides every other input.

Test Plan:
- Reset release with RESET_PC=0, halt=0, imem_ready=1, dec_ready=1, memory returns 0x8C010004, 0x00221820 → imem_addr 0x0, 0x4; ins_valid pulses every 2nd cycle; opcode 0x23 then 0x00; ins_pc 0x0, 0x4; fetch_count=2.
- imem_ready held low 3 cycles at addr 0x8 → imem_req stays 1 and imem_addr stays 0x8 for 4 cycles; ins_valid=0 throughout; capture on the 4th cycle.
- Instruction 0xAC010008 held with dec_ready=0 for 5 cycles → ins_valid=1 and ins, ins_pc unchanged; imem_req=0; fetch_count unchanged; accepted on the 6th cycle, fetch_count increments by 1.
- Held ins=0x1000FFFE at ins_pc=0x8, branch=1, zero=1 on accept → next imem_addr=0x4. Same instruction with zero=0 → next imem_addr=0xC.
- halt=1 in S_FETCH with imem_ready=1 for 4 cycles → imem_req=0, no capture, pc unchanged. halt=0 → request resumes at the same address.
- rst_n pulled low mid-wait in S_FETCH at pc=0x10, and again in S_HOLD → immediately ins_valid=0 and fetch_count=0; after release imem_addr=RESET_PC and ins=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one word per instruction from
// instruction memory, and hands it to decode over a valid/ready handshake.
//
// state   | meaning
// S_FETCH | request imem at pc (unless halted), wait for imem_ready
// S_HOLD  | present the captured instruction to decode until dec_ready
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  input  logic        dec_ready,
  output logic [31:0] ins,
  output logic [5:0]  opcode,
  output logic [31:0] ins_pc,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state;
  logic [31:0] pc;
  logic        capture;
  logic [31:0] br_offset;
  logic [31:0] br_target;

  assign imem_req  = (state == S_FETCH) && !halt;
  assign imem_addr = pc;
  assign capture   = imem_req && imem_ready;
  assign opcode    = ins[31:26];

  // Word offset shifted into byte units; the low two bits stay zero.
  assign br_offset = {{14{ins[15]}}, ins[15:0], 2'b00};
  assign br_target = ins_pc + 32'd4 + br_offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC_ALIGNED;
      ins         <= 32'h0;
      ins_pc      <= 32'h0;
      ins_valid   <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        S_FETCH: begin
          if (capture) begin
            ins       <= imem_rdata;
            ins_pc    <= pc;
            pc        <= pc + 32'd4;
            ins_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (dec_ready) begin
            fetch_count <= fetch_count + 32'd1;
            ins_valid   <= 1'b0;
            state       <= S_FETCH;
            // pc already holds ins_pc+4 from capture; only a taken beq overrides it.
            if (branch && zero) begin
              pc <= br_target;
            end
          end
        end
      endcase
    end
  end

endmodule
